mmio_ctrl: RTL and testbench

Memory-mapped I/O controller for the RISC-V core. Decodes the execute-stage memory address and produces the registered `mem_sel` that drives writeback source selection. Sequences UART traffic through ready/valid handshakes and a one-entry transmit holding buffer. Maintains the cycle and retired-instruction counters, and returns all MMIO read data on `uart_out` with the same one-cycle latency as DMEM/BIOS.

---
 rtl/mmio_pkg.sv | 31 +++
 rtl/mmio_tx_buffer.sv | 53 +++++
 rtl/mmio_ctrl.sv | 116 +++++++++++
 tb/tb_mmio_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - region nibbles, MMIO offsets, mem_sel encodings and TX state for mmio_ctrl
package mmio_pkg;

  localparam logic [3:0] REGION_BIOS = 4'b0100;
  localparam logic [3:0] REGION_MMIO = 4'b1000;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CLR    = 8'h18;

  localparam logic [1:0] MEM_SEL_DMEM = 2'b00;
  localparam logic [1:0] MEM_SEL_MMIO = 2'b01;
  localparam logic [1:0] MEM_SEL_BIOS = 2'b10;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_e;

  function automatic logic [1:0] decode_region(input logic [3:0] nib);
    case (nib)
      REGION_BIOS: decode_region = MEM_SEL_BIOS;
      REGION_MMIO: decode_region = MEM_SEL_MMIO;
      default:     decode_region = MEM_SEL_DMEM;
    endcase
  endfunction

endpackage

// File: rtl/mmio_tx_buffer.sv
// rtl/mmio_tx_buffer.sv - one-entry UART transmit holding register and TX FSM
module mmio_tx_buffer
  import mmio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  output logic       free,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready
);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      TX_IDLE: begin
        if (load) begin
          state_d = TX_PEND;
          data_d  = din;
        end
      end
      TX_PEND: begin
        // A store only lands while pending if the held byte leaves this same edge.
        if (uart_tx_ready) begin
          if (load) data_d = din;
          else      state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign free          = (state_q == TX_IDLE);
  assign uart_tx_valid = (state_q == TX_PEND);
  assign uart_tx_data  = data_q;

endmodule

// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - MMIO decode, UART sequencing and perf counters; MMIO_COUNTERS_EN builds the counters
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] wdata,
  input  logic        stall,
  input  logic        inst_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [31:0] uart_out,
  output logic [1:0]  mem_sel
);

  logic        is_mmio, rd_en, wr_en, tx_load, tx_free;
  logic [7:0]  offset;
  logic [31:0] rdata, cyc_rd, inst_rd;
  logic [31:0] uart_out_q, uart_out_d;
  logic [1:0]  mem_sel_q, mem_sel_d;

  assign is_mmio = (addr[31:28] == REGION_MMIO);
  assign offset  = addr[7:0];
  assign rd_en   = mem_rd & ~stall & is_mmio;
  assign wr_en   = mem_wr & ~stall & is_mmio;
  assign tx_load = wr_en & (offset == OFF_TX);

  assign uart_rx_ready = rst_n & rd_en & (offset == OFF_RX) & uart_rx_valid;

  mmio_tx_buffer u_tx (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (tx_load),
    .din           (wdata[7:0]),
    .free          (tx_free),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready)
  );

`ifdef MMIO_COUNTERS_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d;
  logic             cnt_clr;

  assign cnt_clr = wr_en & (offset == OFF_CLR);

  always_comb begin
    cyc_d  = cnt_clr ? '0 : cyc_q + CNT_W'(1);
    inst_d = inst_q;
    if (cnt_clr)          inst_d = '0;
    else if (inst_retire) inst_d = inst_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
    end
  end

  assign cyc_rd  = 32'(cyc_q);
  assign inst_rd = 32'(inst_q);

  logic unused_bits;
  assign unused_bits = ^{addr[27:8], wdata[31:8]};
`else
  assign cyc_rd  = 32'h0;
  assign inst_rd = 32'h0;

  logic unused_bits;
  assign unused_bits = ^{addr[27:8], wdata[31:8], inst_retire, 32'(CNT_W)};
`endif

  always_comb begin
    rdata = 32'h0;
    case (offset)
      OFF_STATUS: rdata = {30'b0, uart_rx_valid, tx_free};
      OFF_RX:     rdata = {24'b0, uart_rx_data};
      OFF_CYC:    rdata = cyc_rd;
      OFF_INST:   rdata = inst_rd;
      default:    rdata = 32'h0;
    endcase
  end

  // mem_sel tracks every non-stalled address so writeback lines up with DMEM/BIOS data.
  always_comb begin
    mem_sel_d  = stall ? mem_sel_q : decode_region(addr[31:28]);
    uart_out_d = rd_en ? rdata : uart_out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_out_q <= 32'h0;
      mem_sel_q  <= MEM_SEL_DMEM;
    end else begin
      uart_out_q <= uart_out_d;
      mem_sel_q  <= mem_sel_d;
    end
  end

  assign uart_out = uart_out_q;
  assign mem_sel  = mem_sel_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - directed self-checking bench for mmio_ctrl
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        mem_rd, mem_wr;
  logic [31:0] wdata;
  logic        stall, inst_retire;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid, uart_rx_ready;
  logic [31:0] uart_out;
  logic [1:0]  mem_sel;

  int checks = 0;
  int errors = 0;

  mmio_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr          (addr),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .wdata         (wdata),
    .stall         (stall),
    .inst_retire   (inst_retire),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_out      (uart_out),
    .mem_sel       (mem_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    mem_rd = 1'b0; mem_wr = 1'b0; stall = 1'b0; inst_retire = 1'b0;
    addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_cyc, exp_inst;
`ifdef MMIO_COUNTERS_EN
    exp_cyc = 32'd1; exp_inst = 32'd0;
`else
    exp_cyc = 32'd0; exp_inst = 32'd0;
`endif
    rst_n = 1'b0;
    mem_rd = 1'b1; addr = 32'h8000_0004; uart_rx_valid = 1'b1;
    step(); step();
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready got %b exp 0", uart_rx_ready); end
    rst_n = 1'b1; uart_rx_valid = 1'b0; idle_bus();
    step();
    checks++; if (uart_out !== 32'h0) begin errors++; $display("FAIL rst_uart_out got %h exp 0", uart_out); end
    checks++; if (mem_sel !== 2'b00) begin errors++; $display("FAIL rst_mem_sel got %b exp 00", mem_sel); end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", uart_tx_valid); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", uart_tx_data); end
    mem_rd = 1'b1; addr = 32'h8000_0010;
    step();
    checks++; if (uart_out !== exp_cyc) begin errors++; $display("FAIL rst_cyc got %0d exp %0d", uart_out, exp_cyc); end
    addr = 32'h8000_0014;
    step();
    checks++; if (uart_out !== exp_inst) begin errors++; $display("FAIL rst_inst got %0d exp %0d", uart_out, exp_inst); end
    idle_bus();
  endtask

  task automatic test_tx();
    uart_tx_ready = 1'b0;
    mem_wr = 1'b1; addr = 32'h8000_0008; wdata = 32'hFFFF_FF41;
    step();
    idle_bus();
    checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_rise got %b exp 1", uart_tx_valid); end
    checks++; if (uart_tx_data !== 8'h41) begin errors++; $display("FAIL tx_data got %h exp 41", uart_tx_data); end
    mem_rd = 1'b1; addr = 32'h8000_0000;
    step();
    idle_bus();
    checks++; if (uart_out !== 32'h0) begin errors++; $display("FAIL tx_status_busy got %h exp 0", uart_out); end
    step();
    checks++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin errors++; $display("FAIL tx_hold got %b/%h exp 1/41", uart_tx_valid, uart_tx_data); end
    uart_tx_ready = 1'b1;
    #1;
    checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_at_ready got %b exp 1", uart_tx_valid); end
    step();
    uart_tx_ready = 1'b0;
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_valid_fall got %b exp 0", uart_tx_valid); end
    mem_rd = 1'b1; addr = 32'h8000_0000;
    step();
    idle_bus();
    checks++; if (uart_out !== 32'h1) begin errors++; $display("FAIL tx_status_free got %h exp 1", uart_out); end
    mem_wr = 1'b1; addr = 32'h0000_0008; wdata = 32'h55;
    step();
    idle_bus();
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_dmem_store got %b exp 0", uart_tx_valid); end
  endtask

  task automatic test_rx();
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    mem_rd = 1'b1; addr = 32'h8000_0004;
    #1;
    checks++; if (uart_rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_pop got %b exp 1", uart_rx_ready); end
    step();
    mem_rd = 1'b0;
    #1;
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_one_cycle got %b exp 0", uart_rx_ready); end
    checks++; if (uart_out !== 32'h0000_005A) begin errors++; $display("FAIL rx_data got %h exp 0000005a", uart_out); end
    stall = 1'b1; mem_rd = 1'b1; uart_rx_data = 8'hC3;
    #1;
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_stall got %b exp 0", uart_rx_ready); end
    step();
    checks++; if (uart_out !== 32'h0000_005A) begin errors++; $display("FAIL rx_stall_hold got %h exp 0000005a", uart_out); end
    stall = 1'b0; uart_rx_valid = 1'b0;
    #1;
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_empty got %b exp 0", uart_rx_ready); end
    idle_bus();
  endtask

  task automatic test_decode();
    logic [31:0] a_tab [6];
    logic [1:0]  s_tab [6];
    a_tab = '{32'h4000_0000, 32'h1000_0000, 32'h8000_0000, 32'h4FFF_FFFC, 32'hC000_0000, 32'h0800_0000};
    s_tab = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      mem_rd = 1'b1; addr = a_tab[i];
      step();
      checks++; if (mem_sel !== s_tab[i]) begin errors++; $display("FAIL decode_%0d addr %h got %b exp %b", i, a_tab[i], mem_sel, s_tab[i]); end
    end
    checks++; if (uart_out !== 32'h1) begin errors++; $display("FAIL decode_non_mmio_hold got %h exp 1", uart_out); end
    stall = 1'b1; addr = 32'h4000_0000;
    step();
    checks++; if (mem_sel !== 2'b00) begin errors++; $display("FAIL decode_stall_hold got %b exp 00", mem_sel); end
    stall = 1'b0; addr = 32'h8000_0020;
    step();
    checks++; if (uart_out !== 32'h0) begin errors++; $display("FAIL decode_bad_offset got %h exp 0", uart_out); end
    idle_bus();
  endtask

  task automatic test_counters();
    logic [31:0] exp_c1, exp_40, exp_c103;
`ifdef MMIO_COUNTERS_EN
    exp_c1 = 32'd1; exp_40 = 32'd40; exp_c103 = 32'd103;
`else
    exp_c1 = 32'd0; exp_40 = 32'd0; exp_c103 = 32'd0;
`endif
    mem_wr = 1'b1; addr = 32'h8000_0018; inst_retire = 1'b1;
    step();
    idle_bus();
    mem_rd = 1'b1; addr = 32'h8000_0014;
    step();
    checks++; if (uart_out !== 32'd0) begin errors++; $display("FAIL cnt_clr_inst got %0d exp 0", uart_out); end
    addr = 32'h8000_0010;
    step();
    checks++; if (uart_out !== exp_c1) begin errors++; $display("FAIL cnt_cyc_after_clr got %0d exp %0d", uart_out, exp_c1); end
    idle_bus();
    for (int i = 0; i < 100; i++) begin
      inst_retire = ((i % 5) < 2);
      step();
    end
    inst_retire = 1'b0;
    mem_rd = 1'b1; addr = 32'h8000_0014;
    step();
    checks++; if (uart_out !== exp_40) begin errors++; $display("FAIL cnt_inst_40 got %0d exp %0d", uart_out, exp_40); end
    addr = 32'h8000_0010;
    step();
    checks++; if (uart_out !== exp_c103) begin errors++; $display("FAIL cnt_cyc_103 got %0d exp %0d", uart_out, exp_c103); end
    idle_bus();
    mem_wr = 1'b1; addr = 32'h8000_0018; inst_retire = 1'b1;
    step();
    idle_bus();
    mem_rd = 1'b1; addr = 32'h8000_0014;
    step();
    checks++; if (uart_out !== 32'd0) begin errors++; $display("FAIL cnt_clr_priority got %0d exp 0", uart_out); end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    uart_tx_ready = 1'b0;
    mem_wr = 1'b1; addr = 32'h8000_0008; wdata = 32'h50;
    step();
    wdata = 32'h42; uart_tx_ready = 1'b1;
    step();
    checks++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h42) begin errors++; $display("FAIL b2b_reload got %b/%h exp 1/42", uart_tx_valid, uart_tx_data); end
    wdata = 32'h43; uart_tx_ready = 1'b0;
    step();
    checks++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h42) begin errors++; $display("FAIL b2b_drop got %b/%h exp 1/42", uart_tx_valid, uart_tx_data); end
    stall = 1'b1; wdata = 32'h44; uart_tx_ready = 1'b1;
    step();
    uart_tx_ready = 1'b0;
    checks++; if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h42) begin errors++; $display("FAIL b2b_stalled_store got %b/%h exp 0/42", uart_tx_valid, uart_tx_data); end
    stall = 1'b0; wdata = 32'h77;
    step();
    idle_bus();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00) begin errors++; $display("FAIL b2b_reset_discard got %b/%h exp 0/00", uart_tx_valid, uart_tx_data); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_bus();
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    test_reset();
    test_tx();
    test_rx();
    test_decode();
    test_counters();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
